wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Two-master Wishbone arbiter in front of `wb_interconnect`. It shares the interconnect's single master port between the Caravel management Wishbone port (M0) and the internal secondary master (M1, e.g. DMA or boot loader). Arbitration is round-robin and held for a whole `cyc` window. A per-transfer watchdog terminates accesses to slaves that never acknowledge.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles of `stb` without `ack` before abort; legal range 2..255.
- `TIMEOUT_DATA`, default 32'hDEAD_BEEF: read data returned on an aborted transfer.

Ports:
- `clk_i`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `m0_wb_dat_i`/`m0_wb_adr_i`  in  32/32  M0 write data / byte address
- `m0_wb_sel_i`/`m0_wb_we_i`/`m0_wb_cyc_i`/`m0_wb_stb_i`  in  4/1/1/1  M0 controls
- `m0_wb_dat_o`/`m0_wb_ack_o`  out  32/1  M0 read data / ack
- `m1_wb_*`: same set and widths as M0, for master 1
- `s_wb_dat_o`/`s_wb_adr_o`/`s_wb_sel_o`/`s_wb_we_o`/`s_wb_cyc_o`/`s_wb_stb_o`  out  32/32/4/1/1/1  to interconnect master port
- `s_wb_dat_i`/`s_wb_ack_i`  in  32/1  from interconnect
- `gnt_o`  out  2  one-hot current grant: bit0 = M0, bit1 = M1
- `timeout_o`  out  1  sticky flag, set on any abort
- `timeout_clr_i`  in  1  synchronous clear of `timeout_o`

## Operation
- A request from Mx means `mx_wb_cyc_i & mx_wb_stb_i`.
- FSM states:
  - **IDLE**: `gnt_o=00`; all `s_wb_*` outputs are 0.
    - Only one master requesting: grant it, go to GNT0 or GNT1.
    - Both requesting: grant the master that is not `last` (1-bit register: 0 = M0 served last).
    - No request: stay in IDLE.
  - **GNT0 / GNT1**: all `s_wb_*` outputs are driven combinationally from the granted master.
    - `s_wb_dat_i` goes combinationally to the granted master's `dat_o`. `s_wb_ack_i` goes combinationally to the granted master's `ack_o`.
    - The granted master holds the bus while its `cyc_i` stays high, so back-to-back `stb` pulses are allowed.
    - On `cyc_i` low: go to IDLE and set `last` to the granted index.
  - **ABORT** (one cycle):
    - `s_wb_cyc_o=0` and `s_wb_stb_o=0`.
    - Granted master gets `ack_o=1` and `dat_o=TIMEOUT_DATA`.
    - Set `timeout_o` and `last`; go to IDLE.
- Non-granted master: `ack_o=0`, `dat_o=0` at all times. Its request stays pending and is not lost.
- Watchdog: 8-bit counter `wdog`.
  - Clears in IDLE, on `s_wb_ack_i`, and while the granted `stb_i` is low.
  - Otherwise increments in GNTx.
  - When `wdog == TIMEOUT_CYCLES-1` with no ack in that cycle, go to ABORT.
- `timeout_clr_i` clears `timeout_o`. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: FSM in IDLE, `last=1` (M0 wins the first tie), `wdog=0`, `gnt_o=00`, `timeout_o=0`. All `s_wb_*` and `mx_wb_ack_o`/`mx_wb_dat_o` are 0.
- Arbitration latency: request sampled at edge N; grant effective and `s_wb_stb_o` high from cycle N+1. There is no combinational path from request to `s_wb_*`.
- Ack path has zero added latency (combinational pass-through).
- A slave ack arriving in the same cycle the counter would expire is treated as a normal ack; no abort occurs.
- Granted master drops `cyc_i` mid-transfer: `s_wb_*` outputs go to 0 the next cycle, and any late slave ack is discarded in IDLE.
- Minimum turnaround between masters is one IDLE cycle with `s_wb_cyc_o=0`.
- Asserting `rst_n` mid-transfer drops all outputs immediately (asynchronous); nothing is replayed.

## Structure
- `wb_pkg` gets:
  - an enum for arbiter states (`ARB_IDLE`, `ARB_GNT0`, `ARB_GNT1`, `ARB_ABORT`);
  - a packed struct grouping one master's request fields (`dat`, `adr`, `sel`, `we`, `cyc`, `stb`), used to mux M0/M1 onto `s_wb_*`.
- Single module; the watchdog is inline, with no sub-module.
- `TIMEOUT_DATA` default lives in `wb_pkg` as a localparam.

## Test plan
- **Single master:** M0 write to 32'h0000_0010; slave acks after 2 cycles.
  - `gnt_o=01` from cycle N+1; `s_wb_adr_o=32'h10`; `m0_wb_ack_o` pulses once; `m1_wb_ack_o` stays 0.
- **Tie:** M0 and M1 request in the same cycle from reset.
  - M0 is granted first. After M0 drops `cyc`, one IDLE cycle follows, then `gnt_o=10`.
- **Fairness:** both masters continuously re-request after each cycle.
  - Grants alternate 01, 10, 01, 10 over 4 transactions.
- **Timeout:** M1 read to an address whose slave never acks, with `TIMEOUT_CYCLES=4`.
  - ABORT is reached 4 cycles after `stb`; `m1_wb_ack_o=1` with `dat=32'hDEAD_BEEF`; `timeout_o=1` until `timeout_clr_i`.
- **Race:** slave ack lands exactly on the expiry cycle.
  - Normal ack with the slave's data; `timeout_o` stays 0.
- **Reset mid-transfer:** `rst_n` asserted while GNT0 is active.
  - All outputs go to 0 asynchronously; after release, the first tie goes to M0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone arbiter types: FSM state encoding, the per-master request bundle,
// and the default read data returned on an aborted transfer.
package wb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT0  = 2'd1,
        ARB_GNT1  = 2'd2,
        ARB_ABORT = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [31:0] dat;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic        cyc;
        logic        stb;
    } wb_req_t;

    localparam logic [31:0] WB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_arbiter.sv
// Round-robin two-master Wishbone arbiter with a per-transfer ack watchdog.
// Bus handshake: a master requests with cyc&stb; a beat completes on the cycle ack_o is high.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = WB_TIMEOUT_DATA
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [31:0] m0_wb_dat_i,
    input  logic [31:0] m0_wb_adr_i,
    input  logic [3:0]  m0_wb_sel_i,
    input  logic        m0_wb_we_i,
    input  logic        m0_wb_cyc_i,
    input  logic        m0_wb_stb_i,
    output logic [31:0] m0_wb_dat_o,
    output logic        m0_wb_ack_o,
    input  logic [31:0] m1_wb_dat_i,
    input  logic [31:0] m1_wb_adr_i,
    input  logic [3:0]  m1_wb_sel_i,
    input  logic        m1_wb_we_i,
    input  logic        m1_wb_cyc_i,
    input  logic        m1_wb_stb_i,
    output logic [31:0] m1_wb_dat_o,
    output logic        m1_wb_ack_o,
    output logic [31:0] s_wb_dat_o,
    output logic [31:0] s_wb_adr_o,
    output logic [3:0]  s_wb_sel_o,
    output logic        s_wb_we_o,
    output logic        s_wb_cyc_o,
    output logic        s_wb_stb_o,
    input  logic [31:0] s_wb_dat_i,
    input  logic        s_wb_ack_i,
    output logic [1:0]  gnt_o,
    output logic        timeout_o,
    input  logic        timeout_clr_i
);

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] wdog_q, wdog_d;
    logic       timeout_q, timeout_d;

    wb_req_t m0_req, m1_req, gnt_req;
    logic    req0, req1, gnt_m1;

    assign m0_req = '{dat: m0_wb_dat_i, adr: m0_wb_adr_i, sel: m0_wb_sel_i,
                      we: m0_wb_we_i, cyc: m0_wb_cyc_i, stb: m0_wb_stb_i};
    assign m1_req = '{dat: m1_wb_dat_i, adr: m1_wb_adr_i, sel: m1_wb_sel_i,
                      we: m1_wb_we_i, cyc: m1_wb_cyc_i, stb: m1_wb_stb_i};

    assign req0 = m0_wb_cyc_i & m0_wb_stb_i;
    assign req1 = m1_wb_cyc_i & m1_wb_stb_i;

    // last_q is updated on entry to ABORT, so during ABORT it names the aborted master.
    assign gnt_m1  = (state_q == ARB_GNT1) || ((state_q == ARB_ABORT) && last_q);
    assign gnt_req = gnt_m1 ? m1_req : m0_req;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        wdog_d    = '0;
        timeout_d = timeout_clr_i ? 1'b0 : timeout_q;
        case (state_q)
            ARB_IDLE: begin
                if (req0 && (!req1 || last_q)) begin
                    state_d = ARB_GNT0;
                end else if (req1) begin
                    state_d = ARB_GNT1;
                end
            end
            ARB_GNT0, ARB_GNT1: begin
                if (!gnt_req.cyc) begin
                    state_d = ARB_IDLE;
                    last_d  = (state_q == ARB_GNT1);
                end else if (gnt_req.stb && !s_wb_ack_i) begin
                    if (wdog_q == WDOG_LAST) begin
                        state_d = ARB_ABORT;
                        last_d  = (state_q == ARB_GNT1);
                    end else begin
                        wdog_d = wdog_q + 8'd1;
                    end
                end
            end
            ARB_ABORT: begin
                state_d   = ARB_IDLE;
                timeout_d = 1'b1;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        s_wb_dat_o  = '0;
        s_wb_adr_o  = '0;
        s_wb_sel_o  = '0;
        s_wb_we_o   = 1'b0;
        s_wb_cyc_o  = 1'b0;
        s_wb_stb_o  = 1'b0;
        m0_wb_dat_o = '0;
        m0_wb_ack_o = 1'b0;
        m1_wb_dat_o = '0;
        m1_wb_ack_o = 1'b0;
        gnt_o       = 2'b00;
        case (state_q)
            ARB_GNT0, ARB_GNT1: begin
                s_wb_dat_o = gnt_req.dat;
                s_wb_adr_o = gnt_req.adr;
                s_wb_sel_o = gnt_req.sel;
                s_wb_we_o  = gnt_req.we;
                s_wb_cyc_o = gnt_req.cyc;
                s_wb_stb_o = gnt_req.stb;
                gnt_o      = gnt_m1 ? 2'b10 : 2'b01;
                if (gnt_m1) begin
                    m1_wb_dat_o = s_wb_dat_i;
                    m1_wb_ack_o = s_wb_ack_i;
                end else begin
                    m0_wb_dat_o = s_wb_dat_i;
                    m0_wb_ack_o = s_wb_ack_i;
                end
            end
            ARB_ABORT: begin
                gnt_o = gnt_m1 ? 2'b10 : 2'b01;
                if (gnt_m1) begin
                    m1_wb_dat_o = TIMEOUT_DATA;
                    m1_wb_ack_o = 1'b1;
                end else begin
                    m0_wb_dat_o = TIMEOUT_DATA;
                    m0_wb_ack_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign timeout_o = timeout_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            last_q    <= 1'b1;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic, all checked
// every cycle against a behavioural model of who owns the bus and how long it has stalled.
module tb_wb_arbiter;

    localparam int          T_CYC   = 4;
    localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] m0_wb_dat_i, m0_wb_adr_i, m1_wb_dat_i, m1_wb_adr_i;
    logic [3:0]  m0_wb_sel_i, m1_wb_sel_i;
    logic        m0_wb_we_i, m0_wb_cyc_i, m0_wb_stb_i;
    logic        m1_wb_we_i, m1_wb_cyc_i, m1_wb_stb_i;
    logic [31:0] m0_wb_dat_o, m1_wb_dat_o;
    logic        m0_wb_ack_o, m1_wb_ack_o;
    logic [31:0] s_wb_dat_o, s_wb_adr_o, s_wb_dat_i;
    logic [3:0]  s_wb_sel_o;
    logic        s_wb_we_o, s_wb_cyc_o, s_wb_stb_o, s_wb_ack_i;
    logic [1:0]  gnt_o;
    logic        timeout_o, timeout_clr_i;

    int checks = 0;
    int errors = 0;

    // Reference model: bus owner (0 none, 1 = M0, 2 = M1), abort-cycle flag,
    // which master was served most recently, consecutive stalled stb cycles, sticky flag.
    int owner;
    bit in_abort;
    int last_served;
    int stall;
    bit exp_to;

    always #5 clk_i = ~clk_i;

    wb_arbiter #(.TIMEOUT_CYCLES(T_CYC)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .m0_wb_dat_i(m0_wb_dat_i), .m0_wb_adr_i(m0_wb_adr_i), .m0_wb_sel_i(m0_wb_sel_i),
        .m0_wb_we_i(m0_wb_we_i), .m0_wb_cyc_i(m0_wb_cyc_i), .m0_wb_stb_i(m0_wb_stb_i),
        .m0_wb_dat_o(m0_wb_dat_o), .m0_wb_ack_o(m0_wb_ack_o),
        .m1_wb_dat_i(m1_wb_dat_i), .m1_wb_adr_i(m1_wb_adr_i), .m1_wb_sel_i(m1_wb_sel_i),
        .m1_wb_we_i(m1_wb_we_i), .m1_wb_cyc_i(m1_wb_cyc_i), .m1_wb_stb_i(m1_wb_stb_i),
        .m1_wb_dat_o(m1_wb_dat_o), .m1_wb_ack_o(m1_wb_ack_o),
        .s_wb_dat_o(s_wb_dat_o), .s_wb_adr_o(s_wb_adr_o), .s_wb_sel_o(s_wb_sel_o),
        .s_wb_we_o(s_wb_we_o), .s_wb_cyc_o(s_wb_cyc_o), .s_wb_stb_o(s_wb_stb_o),
        .s_wb_dat_i(s_wb_dat_i), .s_wb_ack_i(s_wb_ack_i),
        .gnt_o(gnt_o), .timeout_o(timeout_o), .timeout_clr_i(timeout_clr_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_wb_dat_i = '0; m0_wb_adr_i = '0; m0_wb_sel_i = '0;
        m0_wb_we_i = 1'b0; m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0;
        m1_wb_dat_i = '0; m1_wb_adr_i = '0; m1_wb_sel_i = '0;
        m1_wb_we_i = 1'b0; m1_wb_cyc_i = 1'b0; m1_wb_stb_i = 1'b0;
        s_wb_dat_i = '0; s_wb_ack_i = 1'b0; timeout_clr_i = 1'b0;
    endtask

    task automatic model_reset();
        owner = 0; in_abort = 1'b0; last_served = 1; stall = 0; exp_to = 1'b0;
    endtask

    task automatic check_outputs();
        logic [31:0] e_adr, e_dat, e_dat0, e_dat1;
        logic [3:0]  e_sel;
        logic        e_we, e_cyc, e_stb, e_ack0, e_ack1;
        logic [1:0]  e_gnt;
        e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0;
        e_dat0 = '0; e_dat1 = '0; e_ack0 = 1'b0; e_ack1 = 1'b0; e_gnt = 2'b00;
        if (owner == 1 && !in_abort) begin
            e_adr = m0_wb_adr_i; e_dat = m0_wb_dat_i; e_sel = m0_wb_sel_i;
            e_we = m0_wb_we_i; e_cyc = m0_wb_cyc_i; e_stb = m0_wb_stb_i; e_gnt = 2'b01;
        end else if (owner == 2 && !in_abort) begin
            e_adr = m1_wb_adr_i; e_dat = m1_wb_dat_i; e_sel = m1_wb_sel_i;
            e_we = m1_wb_we_i; e_cyc = m1_wb_cyc_i; e_stb = m1_wb_stb_i; e_gnt = 2'b10;
        end
        if (owner == 1) begin
            e_ack0 = in_abort ? 1'b1 : s_wb_ack_i;
            e_dat0 = in_abort ? TO_DATA : s_wb_dat_i;
        end else if (owner == 2) begin
            e_ack1 = in_abort ? 1'b1 : s_wb_ack_i;
            e_dat1 = in_abort ? TO_DATA : s_wb_dat_i;
        end
        if (!in_abort) chk("gnt", gnt_o, e_gnt);
        chk("s_adr", s_wb_adr_o, e_adr);
        chk("s_dat", s_wb_dat_o, e_dat);
        chk("s_sel", s_wb_sel_o, e_sel);
        chk("s_we", s_wb_we_o, e_we);
        chk("s_cyc", s_wb_cyc_o, e_cyc);
        chk("s_stb", s_wb_stb_o, e_stb);
        chk("m0_ack", m0_wb_ack_o, e_ack0);
        chk("m0_dat", m0_wb_dat_o, e_dat0);
        chk("m1_ack", m1_wb_ack_o, e_ack1);
        chk("m1_dat", m1_wb_dat_o, e_dat1);
        chk("timeout", timeout_o, exp_to);
    endtask

    task automatic model_step();
        bit r0, r1, g_cyc, g_stb;
        r0 = m0_wb_cyc_i & m0_wb_stb_i;
        r1 = m1_wb_cyc_i & m1_wb_stb_i;
        if (in_abort) begin
            exp_to = 1'b1; owner = 0; in_abort = 1'b0; stall = 0;
            return;
        end
        if (timeout_clr_i) exp_to = 1'b0;
        if (owner == 0) begin
            stall = 0;
            if (r0 && r1) owner = (last_served == 0) ? 2 : 1;
            else if (r0) owner = 1;
            else if (r1) owner = 2;
        end else begin
            g_cyc = (owner == 1) ? m0_wb_cyc_i : m1_wb_cyc_i;
            g_stb = (owner == 1) ? m0_wb_stb_i : m1_wb_stb_i;
            if (!g_cyc) begin
                last_served = owner - 1; owner = 0; stall = 0;
            end else if (g_stb && !s_wb_ack_i) begin
                stall++;
                if (stall == T_CYC) begin
                    in_abort = 1'b1; last_served = owner - 1; stall = 0;
                end
            end else begin
                stall = 0;
            end
        end
    endtask

    // One clock: check at the falling edge, advance the model, return 1 time unit past the rising edge.
    task automatic cycle();
        @(negedge clk_i);
        check_outputs();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check_outputs();
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        do_reset();

        // Single master M0 write, slave acks on the third granted cycle
        m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; m0_wb_we_i = 1'b1;
        m0_wb_adr_i = 32'h0000_0010; m0_wb_dat_i = 32'hA5A5_0001; m0_wb_sel_i = 4'hF;
        #1;
        chk("no_comb_req_path", s_wb_stb_o, 1'b0);
        cycle();
        chk("single_gnt", gnt_o, 2'b01);
        chk("single_adr", s_wb_adr_o, 32'h10);
        chk("single_stb", s_wb_stb_o, 1'b1);
        cycle();
        cycle();
        s_wb_ack_i = 1'b1; s_wb_dat_i = 32'h0BAD_F00D;
        #1;
        chk("single_ack", m0_wb_ack_o, 1'b1);
        chk("single_m1_ack", m1_wb_ack_o, 1'b0);
        cycle();
        s_wb_ack_i = 1'b0;
        cycle();
        m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0;
        cycle();
        cycle();

        // Tie from reset goes to M0, then one IDLE cycle, then M1
        do_reset();
        m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; m0_wb_adr_i = 32'h100;
        m1_wb_cyc_i = 1'b1; m1_wb_stb_i = 1'b1; m1_wb_adr_i = 32'h200;
        cycle();
        chk("tie_first", gnt_o, 2'b01);
        s_wb_ack_i = 1'b1;
        cycle();
        s_wb_ack_i = 1'b0; m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0;
        cycle();
        chk("tie_idle_gnt", gnt_o, 2'b00);
        chk("tie_idle_cyc", s_wb_cyc_o, 1'b0);
        cycle();
        chk("tie_second", gnt_o, 2'b10);
        m1_wb_cyc_i = 1'b0; m1_wb_stb_i = 1'b0;
        cycle();

        // Fairness: both keep requesting; grants alternate
        do_reset();
        m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1;
        m1_wb_cyc_i = 1'b1; m1_wb_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("fair_gnt", gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            s_wb_ack_i = 1'b1;
            cycle();
            s_wb_ack_i = 1'b0;
            if (i % 2 == 0) begin m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0; end
            else begin m1_wb_cyc_i = 1'b0; m1_wb_stb_i = 1'b0; end
            cycle();
            m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1;
            m1_wb_cyc_i = 1'b1; m1_wb_stb_i = 1'b1;
        end
        idle_inputs();
        cycle();
        cycle();

        // Timeout: M1 read never acked
        m1_wb_cyc_i = 1'b1; m1_wb_stb_i = 1'b1; m1_wb_adr_i = 32'h3000_0000;
        cycle();
        chk("to_gnt", gnt_o, 2'b10);
        for (int i = 0; i < T_CYC; i++) cycle();
        chk("to_ack", m1_wb_ack_o, 1'b1);
        chk("to_dat", m1_wb_dat_o, 32'hDEAD_BEEF);
        chk("to_cyc", s_wb_cyc_o, 1'b0);
        chk("to_m0_ack", m0_wb_ack_o, 1'b0);
        m1_wb_cyc_i = 1'b0; m1_wb_stb_i = 1'b0;
        cycle();
        chk("to_flag", timeout_o, 1'b1);
        cycle();
        cycle();
        chk("to_sticky", timeout_o, 1'b1);
        timeout_clr_i = 1'b1;
        cycle();
        timeout_clr_i = 1'b0;
        chk("to_clear", timeout_o, 1'b0);

        // Race: ack lands on the expiry cycle
        m1_wb_cyc_i = 1'b1; m1_wb_stb_i = 1'b1; m1_wb_adr_i = 32'h3000_0004;
        cycle();
        for (int i = 0; i < T_CYC - 1; i++) cycle();
        s_wb_ack_i = 1'b1; s_wb_dat_i = 32'h1234_5678;
        #1;
        chk("race_ack", m1_wb_ack_o, 1'b1);
        chk("race_dat", m1_wb_dat_o, 32'h1234_5678);
        cycle();
        s_wb_ack_i = 1'b0;
        #1;
        chk("race_no_abort", s_wb_cyc_o, 1'b1);
        m1_wb_cyc_i = 1'b0; m1_wb_stb_i = 1'b0;
        cycle();
        cycle();
        chk("race_flag", timeout_o, 1'b0);

        // Reset mid-transfer, then the first tie goes to M0
        m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1; m0_wb_adr_i = 32'h40;
        cycle();
        chk("rst_pre_gnt", gnt_o, 2'b01);
        s_wb_ack_i = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("rst_async_gnt", gnt_o, 2'b00);
        idle_inputs();
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        m0_wb_cyc_i = 1'b1; m0_wb_stb_i = 1'b1;
        m1_wb_cyc_i = 1'b1; m1_wb_stb_i = 1'b1;
        cycle();
        chk("rst_tie", gnt_o, 2'b01);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 4) == 0) m0_wb_cyc_i = ~m0_wb_cyc_i;
            if ($urandom_range(0, 4) == 0) m1_wb_cyc_i = ~m1_wb_cyc_i;
            m0_wb_stb_i = ($urandom_range(0, 3) != 0);
            m1_wb_stb_i = ($urandom_range(0, 3) != 0);
            m0_wb_adr_i = $urandom(); m0_wb_dat_i = $urandom();
            m1_wb_adr_i = $urandom(); m1_wb_dat_i = $urandom();
            m0_wb_sel_i = 4'($urandom_range(0, 15)); m1_wb_sel_i = 4'($urandom_range(0, 15));
            m0_wb_we_i = ($urandom_range(0, 1) == 1); m1_wb_we_i = ($urandom_range(0, 1) == 1);
            s_wb_ack_i = ($urandom_range(0, 2) == 0);
            s_wb_dat_i = $urandom();
            timeout_clr_i = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
